data_ram_resp: RTL and testbench
================================

DATA_RAM_RESP -- requirements
Module: data_ram_resp

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of word count (1024 x 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, wait states between accept and response (legal range 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port W_req_valid  input  1  MEM-stage request present.
REQ-006 SHALL have port W_req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port W_req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port W_req_be  input  4  byte-lane enables for stores; bit i covers data bits [8i+7:8i].
REQ-009 SHALL have port W_req_addr  input  32  byte address.
REQ-010 SHALL have port W_req_wdata  input  32  store data, already lane-aligned.
REQ-011 SHALL have port W_resp_valid  output  1  one-cycle completion pulse, loads and stores.
REQ-012 SHALL have port W_data_ram_r_data  output  32  load data consumed by the MEM stage.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-014 W_req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where W_req_valid and W_req_ready are both 1.
REQ-015 On accept, SHALL latch we, be, addr and wdata; go to WAIT with counter = WAIT_CYCLES, or straight to RESP if WAIT_CYCLES = 0.
REQ-016 In WAIT, SHALL decrement the counter each cycle and enter RESP on the edge where it reaches 0.
REQ-017 W_resp_valid SHALL be 1 exactly in the RESP cycle, i.e. WAIT_CYCLES+1 cycles after the accepting edge; RESP returns to IDLE on the next edge.
REQ-018 Word index SHALL be addr[DEPTH_LOG2+1:2]; higher address bits are ignored, so accesses wrap modulo the RAM size.
REQ-019 A store SHALL update only enabled lanes, on the edge entering RESP; be = 4'b0000 completes with no memory change.
REQ-020 A load SHALL drive the full addressed word on W_data_ram_r_data during RESP.
REQ-021 W_data_ram_r_data SHALL hold its value until the next load response; stores leave it unchanged.
REQ-022 W_req_valid during WAIT or RESP SHALL be ignored; back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
REQ-023 A load after a store to the same word SHALL return the stored lanes merged with the unmodified old lanes.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, counter 0, W_req_ready 0 while asserted, W_resp_valid 0 and W_data_ram_r_data 0.
REQ-025 W_req_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-026 Reset during WAIT SHALL drop the pending request, with no store performed and no response issued.
REQ-027 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro DRAM_ALIGN_CHECK_EN defined SHALL add output port W_addr_err (1 bit, reset 0), pulsed in RESP for a misaligned access.
REQ-029 With DRAM_ALIGN_CHECK_EN, an access SHALL be misaligned if be = 4'hF and addr[1:0] != 0, or be in {4'b0011, 4'b1100} and addr[0] != 0.
REQ-030 With DRAM_ALIGN_CHECK_EN, a misaligned store SHALL leave memory unchanged and a misaligned load SHALL return 32'h0.
REQ-031 Without DRAM_ALIGN_CHECK_EN, W_addr_err SHALL be absent and addr[1:0] ignored.

Verification
REQ-032 WAIT_CYCLES=1: store 0xDEADBEEF be=F addr 0x10, then load 0x10 -> each resp_valid 2 cycles after accept; r_data = 0xDEADBEEF.
REQ-033 Store 0x000000AA be=0001 to a word holding 0x11223344, then load it -> r_data = 0x112233AA.
REQ-034 Load addr 0x1000 after store 0x55 to 0x0 (DEPTH_LOG2=10) -> wrap, r_data = 0x00000055.
REQ-035 Hold W_req_valid high through WAIT/RESP -> single response, ready low, next accept only after return to IDLE.
REQ-036 Assert rst_n low in WAIT of a store -> no resp_valid, word unchanged on later load, ready=1 after release.
REQ-037 With DRAM_ALIGN_CHECK_EN, store be=F addr 0x12 -> W_addr_err=1 with resp_valid, memory unchanged; WAIT_CYCLES=0 -> resp next cycle.

Source files
------------

// File: rtl/data_ram_resp.sv
// Data RAM responder for the MEM stage.
// Accepts one load/store request while idle, waits WAIT_CYCLES cycles,
// then issues a one-cycle completion pulse. Stores write only the enabled
// byte lanes on the edge entering RESP; loads capture the addressed word
// on that same edge and hold it on W_data_ram_r_data until the next load.
// Optional feature macro: DRAM_ALIGN_CHECK_EN adds W_addr_err, which flags
// misaligned accesses; such accesses store nothing and load zero.
module data_ram_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        W_req_valid,
  output logic        W_req_ready,
  input  logic        W_req_we,
  input  logic [3:0]  W_req_be,
  input  logic [31:0] W_req_addr,
  input  logic [31:0] W_req_wdata,
  output logic        W_resp_valid,
  output logic [31:0] W_data_ram_r_data
`ifdef DRAM_ALIGN_CHECK_EN
  ,
  output logic        W_addr_err
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic [3:0]  w_next_cnt;

  // Request captured at accept; used when the response is produced later.
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic [31:0] r_mem [0:DEPTH-1];
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_enter_resp;
  logic        w_cur_we;
  logic [3:0]  w_cur_be;
  logic [31:0] w_cur_addr;
  logic [31:0] w_cur_wdata;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic        w_misalign;
  logic        w_do_store;
  logic        w_do_load;

  // Ready is forced low while reset is held, even though the state is IDLE.
  assign W_req_ready  = (r_state == IDLE) && rst_n;
  assign W_resp_valid = (r_state == RESP);
  assign W_data_ram_r_data = r_rdata;
  assign w_accept     = W_req_valid && W_req_ready;

  // With zero wait states the RAM is touched on the accepting edge itself,
  // before the request registers hold it, so take the live inputs then.
  assign w_cur_we    = (r_state == IDLE) ? W_req_we    : r_we;
  assign w_cur_be    = (r_state == IDLE) ? W_req_be    : r_be;
  assign w_cur_addr  = (r_state == IDLE) ? W_req_addr  : r_addr;
  assign w_cur_wdata = (r_state == IDLE) ? W_req_wdata : r_wdata;

  // Upper address bits are dropped so accesses wrap modulo the RAM size.
  assign w_idx = w_cur_addr[DEPTH_LOG2+1:2];

`ifdef DRAM_ALIGN_CHECK_EN
  assign w_misalign = ((w_cur_be == 4'hF) && (w_cur_addr[1:0] != 2'b00)) ||
                      (((w_cur_be == 4'b0011) || (w_cur_be == 4'b1100)) &&
                       w_cur_addr[0]);
`else
  assign w_misalign = 1'b0;
`endif

  logic w_unused_addr;
  assign w_unused_addr = ^{w_cur_addr[31:DEPTH_LOG2+2], w_cur_addr[1:0]};

  assign w_enter_resp = (w_next_state == RESP) && (r_state != RESP);
  assign w_do_store   = w_enter_resp && w_cur_we && !w_misalign;
  assign w_do_load    = w_enter_resp && !w_cur_we;

  // State and wait counter register; reset drops any pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next-state and counter logic: IDLE -> WAIT (or RESP) -> RESP -> IDLE.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_next_state = RESP;
            w_next_cnt   = 4'd0;
          end else begin
            w_next_state = WAIT;
            w_next_cnt   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_next_state = RESP;
          w_next_cnt   = 4'd0;
        end else begin
          w_next_cnt   = r_cnt - 4'd1;
        end
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  // Capture the request fields on the accepting edge.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= W_req_we;
      r_be    <= W_req_be;
      r_addr  <= W_req_addr;
      r_wdata <= W_req_wdata;
    end
  end

  // Byte-lane store into the RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_cur_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_cur_wdata[8*i +: 8];
        end
      end
    end
  end

  // Load data register: updated only by loads, held across stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'h0;
    end else if (w_do_load) begin
      r_rdata <= w_misalign ? 32'h0 : r_mem[w_idx];
    end
  end

`ifdef DRAM_ALIGN_CHECK_EN
  logic r_addr_err;

  // Misalignment flag, valid only alongside the response pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_enter_resp && w_misalign;
    end
  end

  assign W_addr_err = r_addr_err;
`endif

endmodule

// File: tb/tb_data_ram_resp.sv
// Self-checking bench for data_ram_resp: directed scenarios plus random
// loads/stores compared against a word-array reference model.
module tb_data_ram_resp;

  localparam int DEPTH_LOG2  = 10;
  localparam int WAIT_CYCLES = 1;
  localparam int DEPTH       = 1 << DEPTH_LOG2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        W_req_valid;
  logic        W_req_ready;
  logic        W_req_we;
  logic [3:0]  W_req_be;
  logic [31:0] W_req_addr;
  logic [31:0] W_req_wdata;
  logic        W_resp_valid;
  logic [31:0] W_data_ram_r_data;
`ifdef DRAM_ALIGN_CHECK_EN
  logic        W_addr_err;
`endif

  int checks = 0;
  int fails  = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_rdata;

  data_ram_resp #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .W_req_valid      (W_req_valid),
    .W_req_ready      (W_req_ready),
    .W_req_we         (W_req_we),
    .W_req_be         (W_req_be),
    .W_req_addr       (W_req_addr),
    .W_req_wdata      (W_req_wdata),
    .W_resp_valid     (W_resp_valid),
    .W_data_ram_r_data(W_data_ram_r_data)
`ifdef DRAM_ALIGN_CHECK_EN
    ,
    .W_addr_err       (W_addr_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_misaligned(input logic [3:0] be, input logic [31:0] addr);
`ifdef DRAM_ALIGN_CHECK_EN
    return ((be == 4'hF) && (addr % 4 != 0)) ||
           (((be == 4'h3) || (be == 4'hC)) && (addr % 2 != 0));
`else
    return 1'b0;
`endif
  endfunction

  // Apply the effect of one completed request to the reference model.
  task automatic model_apply(input logic we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata);
    int idx;
    logic [31:0] mask;
    idx = int'((addr / 4) % DEPTH);
    if (is_misaligned(be, addr)) begin
      if (!we) exp_rdata = 32'h0;
    end else if (we) begin
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      model_mem[idx] = (model_mem[idx] & ~mask) | (wdata & mask);
    end else begin
      exp_rdata = model_mem[idx];
    end
  endtask

  // Issue one request from IDLE and check handshake, latency and result.
  // Entered and left shortly after a falling edge.
  task automatic do_req(input string tag, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    logic exp_err;
    chk({tag, " ready"}, 32'(W_req_ready), 32'd1);
    W_req_valid = 1'b1;
    W_req_we    = we;
    W_req_be    = be;
    W_req_addr  = addr;
    W_req_wdata = wdata;
    @(posedge clk);
    #1;
    W_req_valid = 1'b0;
    W_req_wdata = $urandom;
    W_req_addr  = $urandom;
    exp_err = is_misaligned(be, addr);
    model_apply(we, be, addr, wdata);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!W_resp_valid && n < 20);
    chk({tag, " latency"}, 32'(n), 32'(WAIT_CYCLES + 1));
    chk({tag, " rdata"}, W_data_ram_r_data, exp_rdata);
`ifdef DRAM_ALIGN_CHECK_EN
    chk({tag, " addr_err"}, 32'(W_addr_err), 32'(exp_err));
`endif
    @(negedge clk);
    chk({tag, " pulse end"}, 32'(W_resp_valid), 32'd0);
    chk({tag, " ready back"}, 32'(W_req_ready), 32'd1);
  endtask

  initial begin
    int w;
    int n_resp;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic        we;

    rst_n       = 1'b0;
    W_req_valid = 1'b0;
    W_req_we    = 1'b0;
    W_req_be    = 4'h0;
    W_req_addr  = 32'h0;
    W_req_wdata = 32'h0;
    exp_rdata   = 32'h0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst ready", 32'(W_req_ready), 32'd0);
    chk("rst resp", 32'(W_resp_valid), 32'd0);
    chk("rst rdata", W_data_ram_r_data, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("ready after rst", 32'(W_req_ready), 32'd1);

    // Store then load a full word
    do_req("st DEADBEEF", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    do_req("ld 0x10", 1'b0, 4'hF, 32'h10, 32'h0);
    chk("ld 0x10 value", W_data_ram_r_data, 32'hDEADBEEF);

    // Single-lane merge
    do_req("st 11223344", 1'b1, 4'hF, 32'h20, 32'h11223344);
    do_req("st AA lane0", 1'b1, 4'h1, 32'h20, 32'h000000AA);
    chk("rdata held over stores", W_data_ram_r_data, 32'hDEADBEEF);
    do_req("ld merged", 1'b0, 4'hF, 32'h20, 32'h0);
    chk("merged value", W_data_ram_r_data, 32'h112233AA);

    // Empty byte enable leaves memory unchanged
    do_req("st be0", 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF);
    do_req("ld after be0", 1'b0, 4'hF, 32'h20, 32'h0);
    chk("be0 unchanged", W_data_ram_r_data, 32'h112233AA);

    // Address wrap modulo RAM size
    do_req("st 55 @0", 1'b1, 4'hF, 32'h0, 32'h00000055);
    do_req("ld 0x1000", 1'b0, 4'hF, 32'h1000, 32'h0);
    chk("wrap value", W_data_ram_r_data, 32'h00000055);

    // Valid held through WAIT/RESP: one response per WAIT_CYCLES+2 cycles
    W_req_valid = 1'b1;
    W_req_we    = 1'b0;
    W_req_be    = 4'hF;
    W_req_addr  = 32'h10;
    n_resp      = 0;
    for (int n = 1; n <= 2 * WAIT_CYCLES + 3; n++) begin
      @(negedge clk);
      chk($sformatf("hold ready n%0d", n), 32'(W_req_ready),
          32'((n % (WAIT_CYCLES + 2)) == 0));
      chk($sformatf("hold resp n%0d", n), 32'(W_resp_valid),
          32'((n % (WAIT_CYCLES + 2)) == WAIT_CYCLES + 1));
      if (W_resp_valid) n_resp++;
    end
    W_req_valid = 1'b0;
    chk("hold resp count", 32'(n_resp), 32'd2);
    exp_rdata = model_mem[4];
    chk("hold rdata", W_data_ram_r_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("hold idle resp", 32'(W_resp_valid), 32'd0);

    // Reset while a store waits: dropped, no pulse, word untouched
    if (WAIT_CYCLES > 0) begin
      W_req_valid = 1'b1;
      W_req_we    = 1'b1;
      W_req_be    = 4'hF;
      W_req_addr  = 32'h10;
      W_req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      W_req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("wait-rst resp", 32'(W_resp_valid), 32'd0);
      chk("wait-rst ready", 32'(W_req_ready), 32'd0);
      chk("wait-rst rdata", W_data_ram_r_data, 32'h0);
      exp_rdata = 32'h0;
      @(posedge clk);
      #1;
      chk("wait-rst no pulse", 32'(W_resp_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("wait-rst ready after", 32'(W_req_ready), 32'd1);
      do_req("ld after rst", 1'b0, 4'hF, 32'h10, 32'h0);
      chk("word kept over rst", W_data_ram_r_data, 32'hDEADBEEF);
    end

`ifdef DRAM_ALIGN_CHECK_EN
    do_req("st misaligned", 1'b1, 4'hF, 32'h12, 32'h12345678);
    do_req("ld after misaligned", 1'b0, 4'hF, 32'h10, 32'h0);
    chk("misaligned no write", W_data_ram_r_data, 32'hDEADBEEF);
`endif

    // Fill a small window of words, then random traffic over it
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      do_req($sformatf("init w%0d", i), 1'b1, 4'hF, 32'(i * 4), d);
    end
    for (int t = 0; t < 40; t++) begin
      w  = int'($urandom_range(0, 15));
      we = 1'($urandom_range(0, 1));
      b  = 4'($urandom_range(0, 15));
      d  = $urandom;
      a  = ($urandom & 32'hFFFFF003) | 32'(w * 4);
      do_req($sformatf("rand%0d", t), we, b, a, d);
    end
    for (int i = 0; i < 16; i++) begin
      do_req($sformatf("final w%0d", i), 1'b0, 4'hF, 32'(i * 4), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
